// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush control: mem>ex>id stall merge, exception flush deferred past mem bus stalls, stuck-stall watchdog.
// Zero-cycle combinational stall/flush; PIPE_CTRL_PERF_EN adds a stalled-cycle performance counter on o_stall_cycles.
`ifndef RST_ENABLE
`define RST_ENABLE 1'b0
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`ifndef N_INST_ADDR
`define N_INST_ADDR 32
`endif

module pipe_ctrl #(
   parameter logic [`N_INST_ADDR-1:0] EXC_VECTOR    = 32'h0000_0020,
   parameter int                      STALL_TIMEOUT = 1023
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_stallreq_id,
   input  logic                    i_stallreq_ex,
   input  logic                    i_stallreq_mem,
   input  logic [31:0]             i_excepttype,
   input  logic [`N_INST_ADDR-1:0] i_cp0_epc,
   output logic [5:0]              o_stall,
   output logic                    o_flush,
   output logic [`N_INST_ADDR-1:0] o_new_pc,
   output logic                    o_stall_timeout,
   output logic [31:0]             o_stall_cycles
);

   localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
   localparam logic [5:0]  STALL_MEM  = 6'b011111;
   localparam logic [5:0]  STALL_EX   = 6'b001111;
   localparam logic [5:0]  STALL_ID   = 6'b000111;
   localparam int          CW         = $clog2(STALL_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STALL_TIMEOUT);

   typedef enum logic [1:0] {RUN, PEND, RECOVER} state_t;

   state_t                  state_q, state_d;
   logic [`N_INST_ADDR-1:0] pend_pc_q, pend_pc_d;
   logic [`N_INST_ADDR-1:0] new_pc;
   logic                    has_exc;
   logic [CW-1:0]           stall_cnt_q, stall_cnt_d;

   assign has_exc = (i_excepttype != 32'd0);
   assign new_pc  = (i_excepttype == EXC_ERET) ? i_cp0_epc : EXC_VECTOR;

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      o_stall   = 6'b000000;
      o_flush   = 1'b0;
      o_new_pc  = '0;
      case (state_q)
         PEND: begin
            // The frozen pipeline keeps presenting the same exception; only the bus release matters.
            if (i_stallreq_mem) begin
               o_stall = STALL_MEM;
            end else begin
               o_flush  = 1'b1;
               o_new_pc = pend_pc_q;
               state_d  = RECOVER;
            end
         end
         default: begin
            if (has_exc) begin
               if (i_stallreq_mem) begin
                  o_stall   = STALL_MEM;
                  pend_pc_d = new_pc;
                  state_d   = PEND;
               end else begin
                  o_flush  = 1'b1;
                  o_new_pc = new_pc;
                  state_d  = RECOVER;
               end
            end else begin
               state_d = RUN;
               // Right after a flush, id/ex hold bubbles so their requests are stale.
               if (i_stallreq_mem)
                  o_stall = STALL_MEM;
               else if (state_q == RUN && i_stallreq_ex)
                  o_stall = STALL_EX;
               else if (state_q == RUN && i_stallreq_id)
                  o_stall = STALL_ID;
            end
         end
      endcase
      if (i_rst_n == `RST_ENABLE) begin
         o_stall  = 6'b000000;
         o_flush  = 1'b0;
         o_new_pc = '0;
      end
   end

   always_comb begin
      stall_cnt_d = '0;
      if (o_stall != 6'b000000)
         stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (i_rst_n == `RST_ENABLE) begin
         state_q         <= RUN;
         pend_pc_q       <= '0;
         stall_cnt_q     <= '0;
         o_stall_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_pc_q   <= pend_pc_d;
         stall_cnt_q <= stall_cnt_d;
         if (stall_cnt_d == CNT_MAX)
            o_stall_timeout <= 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (i_rst_n == `RST_ENABLE)
         perf_q <= 32'd0;
      else if (o_stall[0] == `STOP)
         perf_q <= perf_q + 32'd1;
   end

   assign o_stall_cycles = perf_q;
`else
   assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 6-stage core (pc, if, id, ex, mem, wb). It merges stall requests into the `i_stall[5:0]` vector consumed by every pipeline register, including if_id. It also drives the single-cycle `i_flush` and the redirect PC on exceptions. If an exception arrives while the mem stage is bus-stalled, the flush is deferred until the stall releases, and a stuck-stall watchdog runs in parallel.

## Interface
Parameters:
- `EXC_VECTOR`, default `32'h0000_0020`: redirect target for every non-eret exception.
- `STALL_TIMEOUT`, default `1023`: consecutive stalled cycles before the watchdog trips.

Ports:
- `i_clk`, input, 1: clock. Single clock domain.
- `i_rst_n`, input, 1: reset. Asynchronous, active-low, compared against `` `RST_ENABLE ``.
- `i_stallreq_id`, input, 1: id stage needs to hold (load-use).
- `i_stallreq_ex`, input, 1: ex stage needs to hold (multi-cycle op).
- `i_stallreq_mem`, input, 1: mem stage bus transaction not complete.
- `i_excepttype`, input, 32: exception code from mem. `0` means none; `32'h0000_000e` means eret.
- `i_cp0_epc`, input, `` `N_INST_ADDR ``: EPC value used for eret.
- `o_stall`, output, 6: per-stage stall vector. Bit 0 is pc, bit 5 is wb; 1 is `` `STOP ``.
- `o_flush`, output, 1: clear pipeline registers this cycle.
- `o_new_pc`, output, `` `N_INST_ADDR ``: redirect target, valid only while `o_flush` is 1, else 0.
- `o_stall_timeout`, output, 1: sticky watchdog flag.
- `o_stall_cycles`, output, 32: performance counter (see Configuration).

## Operation
- Stall encoding, priority mem > ex > id:
  - mem request gives `6'b011111`.
  - ex request gives `6'b001111`.
  - id request gives `6'b000111`.
  - no request gives `6'b000000`.
- `new_pc` computation: `i_excepttype == 32'h0000_000e` selects `i_cp0_epc`. Any other nonzero value selects `EXC_VECTOR`.
- State `RUN`:
  - `exc != 0` and `i_stallreq_mem == 0`: `o_flush = 1`, `o_stall = 0`, `o_new_pc = new_pc`. Next state `RECOVER`.
  - `exc != 0` and `i_stallreq_mem == 1`: latch `new_pc` into `pend_pc`, `o_flush = 0`, `o_stall = 6'b011111`. Next state `PEND`.
  - `exc == 0`: `o_stall` follows the encoding above. Stay in `RUN`.
- State `PEND`:
  - `i_excepttype` is ignored; the pipeline is frozen and still presents the same exception.
  - While `i_stallreq_mem == 1`: `o_stall = 6'b011111`.
  - When `i_stallreq_mem` drops: `o_flush = 1`, `o_new_pc = pend_pc`, `o_stall = 0`. Next state `RECOVER`.
- State `RECOVER`, exactly one cycle:
  - The id and ex requests are stale (those stages hold bubbles), so both are masked.
  - `o_stall = 6'b011111` if `i_stallreq_mem`, else 0.
  - A new `exc != 0` here is handled as in `RUN`, including the deferral case.
  - Otherwise next state `RUN`.
- Flush always forces `o_stall = 0` in the same cycle.
- Watchdog:
  - `stall_cnt` increments each cycle with `o_stall != 0` and clears on any cycle with `o_stall == 0`.
  - The counter saturates at `STALL_TIMEOUT`.
  - When `stall_cnt == STALL_TIMEOUT`, `o_stall_timeout` is set and stays set until reset.
  - Counter width is `$clog2(STALL_TIMEOUT+1)`.

## Timing
- `o_stall`, `o_flush` and `o_new_pc` are combinational from inputs and state. There is zero-cycle latency from request to stall.
- State, `pend_pc`, `stall_cnt`, `o_stall_timeout` and `o_stall_cycles` are registered on the `i_clk` rising edge.
- While `i_rst_n` is low, everything is forced to its reset value:
  - state `RUN`, `pend_pc = 0`, `stall_cnt = 0`.
  - `o_stall = 0`, `o_flush = 0`, `o_new_pc = 0`, `o_stall_timeout = 0`, `o_stall_cycles = 0`.
- `o_flush` is high for exactly one cycle per exception, never on two consecutive cycles from the same exception.
- Deferred flush: it occurs in the first cycle with `i_stallreq_mem == 0` after entry to `PEND`.
- Reset asserted during `PEND` discards the pending exception; no flush follows.
- Watchdog trip: with `STALL_TIMEOUT = N` and stall asserted from cycle 0, `o_stall_timeout` rises at the edge ending cycle N-1.

## Configuration
- Macro: `PIPE_CTRL_PERF_EN`.
- Defined:
  - `o_stall_cycles` increments each cycle with `o_stall[0] == `STOP`.
  - It wraps from `32'hFFFF_FFFF` to 0.
  - It is not cleared by flush.
- Undefined: `o_stall_cycles` is tied to 0 and no counter flops are built.
- The port exists in both builds.

## Test plan
- Hold `i_stallreq_ex = 1` and `i_stallreq_id = 1` for 3 cycles. Expect `o_stall = 6'b001111` for those 3 cycles, 0 after, `o_flush = 0`.
- `i_excepttype = 32'h8` for 1 cycle, no stalls. Expect `o_flush = 1` and `o_new_pc = 32'h20` that cycle. Next cycle, `i_stallreq_id = 1` is masked (`o_stall = 0`).
- `i_excepttype = 32'he` with `i_cp0_epc = 32'h0000_1234`. Expect `o_flush = 1`, `o_new_pc = 32'h1234`.
- `i_stallreq_mem = 1` for 4 cycles with `i_excepttype = 32'hc` throughout. Expect `o_stall = 6'b011111` and `o_flush = 0` for 4 cycles, then on cycle 5 `o_flush = 1`, `o_new_pc = 32'h20`.
- `STALL_TIMEOUT = 8`, `i_stallreq_mem` held high. Expect `o_stall_timeout` = 1 after 8 cycles, still 1 after the request drops.
- With the macro defined, 10 stalled cycles, reset, then 5 stalled cycles: expect `o_stall_cycles` = 10, then 0, then 5. Without the macro, it is always 0.
